// File: rtl/time_pkg.sv
// Shared definitions for the time-mark measurement path: lock FSM encoding
// and the clock/mark constants the default expected period is derived from.
package time_pkg;

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    localparam int CLK_HZ     = 20_000_000;
    localparam int MARK_CYC   = 32_000_000;
    localparam int DEF_EXP_US = MARK_CYC / 20;

endpackage

// File: rtl/edge_det_sync.sv
// Rising-edge detector with an optional synchroniser chain in front.
// The rise pulse is registered, so an edge sampled at clock k is seen at k+1+SYNC_STAGES.
module edge_det_sync #(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk20mhz,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic synced;
    logic prev;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign synced = din;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk20mhz or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= din;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign synced = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk20mhz or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            prev <= synced;
            rise <= synced & ~prev;
        end
    end

endmodule

// File: rtl/time_mark_meter.sv
// Measures the timing generator's mark period in 1 us ticks, qualifies it with
// a lock FSM, and timestamps external events as {mark number, us offset}.
module time_mark_meter
    import time_pkg::*;
#(
    parameter int EXP_US = DEF_EXP_US,
    parameter int TOL_US = 4,
    parameter int LOCK_N = 3,
    parameter int USW    = 24,
    parameter int MKW    = 16
) (
    input  logic           clk20mhz,
    input  logic           rst_n,
    input  logic           t1us_in,
    input  logic           mark_in,
    input  logic           evt_in,
    input  logic           evt_ack,
    output logic [USW-1:0] us_cnt,
    output logic [MKW-1:0] mark_cnt,
    output logic [USW-1:0] period_us,
    output logic           period_vld,
    output logic           lock,
    output logic           err_short,
    output logic           err_long,
    input  logic           err_clr,
    output logic [USW-1:0] evt_us,
    output logic [MKW-1:0] evt_mark,
    output logic           evt_vld,
    output logic           evt_ovr
);

    localparam logic [USW-1:0] LO_LIM = USW'(EXP_US - TOL_US);
    localparam logic [USW-1:0] HI_LIM = USW'(EXP_US + TOL_US);
    localparam int             GW     = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;
    localparam logic [GW-1:0]  GOOD_LAST = GW'(LOCK_N - 1);

    logic           tick, mark, evt_rise;
    logic [USW-1:0] us_plus, period_meas, us_nx;
    logic [MKW-1:0] mark_nx;
    logic           good_period, timeout;
    logic           set_short, set_long;
    lock_state_t    state, state_nx;
    logic [GW-1:0]  good_cnt, good_nx;

    edge_det_sync #(.SYNC_STAGES(0)) u_tick_det (
        .clk20mhz (clk20mhz), .rst_n (rst_n), .din (t1us_in), .rise (tick)
    );
    edge_det_sync #(.SYNC_STAGES(0)) u_mark_det (
        .clk20mhz (clk20mhz), .rst_n (rst_n), .din (mark_in), .rise (mark)
    );
    edge_det_sync #(.SYNC_STAGES(2)) u_evt_det (
        .clk20mhz (clk20mhz), .rst_n (rst_n), .din (evt_in), .rise (evt_rise)
    );

    // A tick landing on the mark cycle still belongs to the period being closed.
    assign us_plus     = (us_cnt == '1) ? us_cnt : us_cnt + 1'b1;
    assign period_meas = tick ? us_plus : us_cnt;
    assign good_period = (period_meas >= LO_LIM) && (period_meas <= HI_LIM);
    assign timeout     = tick && !mark && (us_cnt == HI_LIM) && (state != UNLOCK);

    always_comb begin
        us_nx   = us_cnt;
        mark_nx = mark_cnt;
        if (mark) begin
            us_nx   = '0;
            mark_nx = mark_cnt + 1'b1;
        end else if (tick) begin
            us_nx = us_plus;
        end
    end

    always_comb begin
        state_nx  = state;
        good_nx   = good_cnt;
        set_short = mark && (state != UNLOCK) && (period_meas < LO_LIM);
        set_long  = timeout || (mark && (state != UNLOCK) && (period_meas > HI_LIM));
        case (state)
            UNLOCK: begin
                if (mark) begin
                    state_nx = ACQ;
                    good_nx  = '0;
                end
            end
            ACQ: begin
                if (mark) begin
                    if (!good_period) begin
                        good_nx = '0;
                    end else if (good_cnt == GOOD_LAST) begin
                        state_nx = LOCKED;
                        good_nx  = '0;
                    end else begin
                        good_nx = good_cnt + 1'b1;
                    end
                end else if (timeout) begin
                    state_nx = UNLOCK;
                end
            end
            LOCKED: begin
                if (mark) begin
                    if (!good_period) begin
                        state_nx = ACQ;
                        good_nx  = '0;
                    end
                end else if (timeout) begin
                    state_nx = UNLOCK;
                end
            end
            default: state_nx = UNLOCK;
        endcase
    end

    always_ff @(posedge clk20mhz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= UNLOCK;
            good_cnt   <= '0;
            lock       <= 1'b0;
            us_cnt     <= '0;
            mark_cnt   <= '0;
            period_us  <= '0;
            period_vld <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
        end else begin
            state      <= state_nx;
            good_cnt   <= good_nx;
            lock       <= (state == LOCKED);
            us_cnt     <= us_nx;
            mark_cnt   <= mark_nx;
            period_vld <= mark;
            if (mark) period_us <= period_meas;
            if (set_short)    err_short <= 1'b1;
            else if (err_clr) err_short <= 1'b0;
            if (set_long)     err_long  <= 1'b1;
            else if (err_clr) err_long  <= 1'b0;
        end
    end

    // An ack in the same cycle as a new event frees the slot for that event.
    always_ff @(posedge clk20mhz or negedge rst_n) begin
        if (!rst_n) begin
            evt_us   <= '0;
            evt_mark <= '0;
            evt_vld  <= 1'b0;
            evt_ovr  <= 1'b0;
        end else if (evt_rise && (!evt_vld || evt_ack)) begin
            evt_us   <= us_nx;
            evt_mark <= mark_nx;
            evt_vld  <= 1'b1;
            evt_ovr  <= 1'b0;
        end else if (evt_rise) begin
            evt_ovr <= 1'b1;
        end else if (evt_ack && evt_vld) begin
            evt_vld <= 1'b0;
            evt_ovr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_time_mark_meter.sv
// Bench for time_mark_meter: table of mark periods, hand-built corner sequences,
// and randomized periods/events compared every cycle against a reference model.
module tb_time_mark_meter;

    localparam int EXP    = 20;
    localparam int TOL    = 2;
    localparam int LOCKN  = 3;
    localparam int USW    = 24;
    localparam int MKW    = 16;
    localparam int LO     = EXP - TOL;
    localparam int HI     = EXP + TOL;
    localparam int US_MAX = (1 << USW) - 1;

    localparam int M_UNLOCK = 0;
    localparam int M_ACQ    = 1;
    localparam int M_LOCKED = 2;

    logic           clk20mhz = 1'b0;
    logic           rst_n;
    logic           t1us_in, mark_in, evt_in, evt_ack, err_clr;
    logic [USW-1:0] us_cnt, period_us, evt_us;
    logic [MKW-1:0] mark_cnt, evt_mark;
    logic           period_vld, lock, err_short, err_long, evt_vld, evt_ovr;

    time_mark_meter #(
        .EXP_US (EXP), .TOL_US (TOL), .LOCK_N (LOCKN), .USW (USW), .MKW (MKW)
    ) dut (
        .clk20mhz   (clk20mhz),
        .rst_n      (rst_n),
        .t1us_in    (t1us_in),
        .mark_in    (mark_in),
        .evt_in     (evt_in),
        .evt_ack    (evt_ack),
        .us_cnt     (us_cnt),
        .mark_cnt   (mark_cnt),
        .period_us  (period_us),
        .period_vld (period_vld),
        .lock       (lock),
        .err_short  (err_short),
        .err_long   (err_long),
        .err_clr    (err_clr),
        .evt_us     (evt_us),
        .evt_mark   (evt_mark),
        .evt_vld    (evt_vld),
        .evt_ovr    (evt_ovr)
    );

    always #5 clk20mhz = ~clk20mhz;

    int    checks   = 0;
    int    failures = 0;
    string phase    = "reset";
    int    marks_sent = 0;
    logic  ev_lvl = 1'b0;

    // Reference model state, plain integers
    int m_us, m_mark, m_period, m_pvld, m_state, m_good, m_lock;
    int m_es, m_el, m_eus, m_emark, m_evld, m_eovr;
    logic [4:0] tk_h, mk_h, ev_h;

    typedef struct {
        int ticks;
        bit coin;
        bit clr;
        int e_period;
        bit e_lock;
        bit e_short;
        bit e_long;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_us = 0; m_mark = 0; m_period = 0; m_pvld = 0; m_state = M_UNLOCK;
        m_good = 0; m_lock = 0; m_es = 0; m_el = 0; m_eus = 0; m_emark = 0;
        m_evld = 0; m_eovr = 0;
        tk_h = '0; mk_h = '0; ev_h = '0;
    endtask

    // Ticks/marks act one clock after they are sampled, events three clocks after.
    task automatic modelEdge(input logic tk, input logic mk, input logic ev,
                             input logic ak, input logic cl);
        bit tick_a, mark_a, evt_a, es_set, el_set;
        int per, lock_next;
        tk_h = {tk_h[3:0], tk};
        mk_h = {mk_h[3:0], mk};
        ev_h = {ev_h[3:0], ev};
        tick_a    = tk_h[1] & ~tk_h[2];
        mark_a    = mk_h[1] & ~mk_h[2];
        evt_a     = ev_h[3] & ~ev_h[4];
        lock_next = (m_state == M_LOCKED) ? 1 : 0;
        es_set = 0;
        el_set = 0;
        if (mark_a) begin
            per = m_us + (tick_a ? 1 : 0);
            if (per > US_MAX) per = US_MAX;
            m_period = per;
            m_pvld   = 1;
            m_us     = 0;
            m_mark   = (m_mark + 1) % (1 << MKW);
            if (m_state == M_UNLOCK) begin
                m_state = M_ACQ;
                m_good  = 0;
            end else if (per < LO || per > HI) begin
                es_set  = (per < LO);
                el_set  = (per > HI);
                m_state = M_ACQ;
                m_good  = 0;
            end else if (m_state == M_ACQ) begin
                m_good++;
                if (m_good == LOCKN) m_state = M_LOCKED;
            end
        end else begin
            m_pvld = 0;
            if (tick_a && m_us < US_MAX) m_us++;
            if (tick_a && m_state != M_UNLOCK && m_us == HI + 1) begin
                el_set  = 1;
                m_state = M_UNLOCK;
            end
        end
        if (es_set) m_es = 1; else if (cl) m_es = 0;
        if (el_set) m_el = 1; else if (cl) m_el = 0;
        if (evt_a) begin
            if (m_evld == 0 || ak) begin
                m_eus = m_us; m_emark = m_mark; m_evld = 1; m_eovr = 0;
            end else begin
                m_eovr = 1;
            end
        end else if (ak && m_evld != 0) begin
            m_evld = 0;
            m_eovr = 0;
        end
        m_lock = lock_next;
    endtask

    task automatic checkOutput();
        chk({phase, ".us_cnt"},     int'(us_cnt),     m_us);
        chk({phase, ".mark_cnt"},   int'(mark_cnt),   m_mark);
        chk({phase, ".period_us"},  int'(period_us),  m_period);
        chk({phase, ".period_vld"}, int'(period_vld), m_pvld);
        chk({phase, ".lock"},       int'(lock),       m_lock);
        chk({phase, ".err_short"},  int'(err_short),  m_es);
        chk({phase, ".err_long"},   int'(err_long),   m_el);
        chk({phase, ".evt_us"},     int'(evt_us),     m_eus);
        chk({phase, ".evt_mark"},   int'(evt_mark),   m_emark);
        chk({phase, ".evt_vld"},    int'(evt_vld),    m_evld);
        chk({phase, ".evt_ovr"},    int'(evt_ovr),    m_eovr);
    endtask

    task automatic step(input logic tk, input logic mk, input logic ev,
                        input logic ak, input logic cl);
        t1us_in = tk; mark_in = mk; evt_in = ev; evt_ack = ak; err_clr = cl;
        @(posedge clk20mhz);
        modelEdge(tk, mk, ev, ak, cl);
        #1;
        checkOutput();
    endtask

    task automatic usTick(input logic mk);
        step(1'b1, mk, ev_lvl, 1'b0, 1'b0);
        step(1'b0, 1'b0, ev_lvl, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, ev_lvl, 1'b0, 1'b0);
    endtask

    // One mark period of n ticks; with coin the last tick lands on the mark.
    task automatic applyStimulus(input int n, input bit coin, input bit clr);
        for (int i = 0; i < n - (coin ? 1 : 0); i++) usTick(1'b0);
        if (clr) step(1'b0, 1'b0, ev_lvl, 1'b0, 1'b1);
        if (coin) usTick(1'b1);
        else begin
            step(1'b0, 1'b1, ev_lvl, 1'b0, 1'b0);
            step(1'b0, 1'b0, ev_lvl, 1'b0, 1'b0);
        end
        marks_sent++;
        idle(3);
    endtask

    // Event edge sampled on the first step acts on the fourth, where ack may join it.
    task automatic evtPulse(input logic ak);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, ak,   1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rstep(input logic tk, input logic mk);
        if ($urandom_range(0, 3) == 0) ev_lvl = ~ev_lvl;
        step(tk, mk, ev_lvl, ($urandom_range(0, 4) == 0), ($urandom_range(0, 40) == 0));
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, ".us_cnt"},     int'(us_cnt),     0);
        chk({tag, ".mark_cnt"},   int'(mark_cnt),   0);
        chk({tag, ".period_us"},  int'(period_us),  0);
        chk({tag, ".period_vld"}, int'(period_vld), 0);
        chk({tag, ".lock"},       int'(lock),       0);
        chk({tag, ".err_short"},  int'(err_short),  0);
        chk({tag, ".err_long"},   int'(err_long),   0);
        chk({tag, ".evt_us"},     int'(evt_us),     0);
        chk({tag, ".evt_mark"},   int'(evt_mark),   0);
        chk({tag, ".evt_vld"},    int'(evt_vld),    0);
        chk({tag, ".evt_ovr"},    int'(evt_ovr),    0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{20, 1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{20, 1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{20, 1'b1, 1'b0, 20, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{20, 1'b0, 1'b0, 20, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{20, 1'b0, 1'b0, 20, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{17, 1'b0, 1'b0, 17, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{23, 1'b0, 1'b0, 23, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{20, 1'b0, 1'b1, 20, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{20, 1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{20, 1'b0, 1'b0, 20, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{23, 1'b1, 1'b0, 23, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{18, 1'b0, 1'b1, 18, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{22, 1'b0, 1'b0, 22, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{22, 1'b1, 1'b0, 22, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        t1us_in = 1'b0; mark_in = 1'b0; evt_in = 1'b0; evt_ack = 1'b0; err_clr = 1'b0;
        modelReset();
        repeat (3) @(posedge clk20mhz);
        #1;
        checkAllZero("init");
        rst_n = 1'b1;

        phase = "table";
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ticks, vecs[i].coin, vecs[i].clr);
            chk($sformatf("tbl%0d.period_us", i), int'(period_us), vecs[i].e_period);
            chk($sformatf("tbl%0d.lock", i),      int'(lock),      vecs[i].e_lock);
            chk($sformatf("tbl%0d.err_short", i), int'(err_short), vecs[i].e_short);
            chk($sformatf("tbl%0d.err_long", i),  int'(err_long),  vecs[i].e_long);
            chk($sformatf("tbl%0d.us_cnt", i),    int'(us_cnt),    0);
            chk($sformatf("tbl%0d.mark_cnt", i),  int'(mark_cnt),  i + 1);
        end

        phase = "errwin";
        for (int i = 0; i < 17; i++) usTick(1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        marks_sent++;
        idle(3);
        chk("errwin.err_short", int'(err_short), 1);
        chk("errwin.lock", int'(lock), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("errwin.cleared", int'(err_short), 0);

        phase = "timeout";
        repeat (3) applyStimulus(20, 1'b0, 1'b0);
        chk("timeout.prelock", int'(lock), 1);
        for (int i = 0; i < 22; i++) usTick(1'b0);
        chk("timeout.us22", int'(us_cnt), 22);
        chk("timeout.el_before", int'(err_long), 0);
        usTick(1'b0);
        chk("timeout.us23", int'(us_cnt), 23);
        chk("timeout.err_long", int'(err_long), 1);
        idle(1);
        chk("timeout.lock", int'(lock), 0);
        for (int i = 0; i < 7; i++) usTick(1'b0);
        chk("timeout.us30", int'(us_cnt), 30);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        marks_sent++;
        idle(3);
        chk("timeout.period", int'(period_us), 30);
        chk("timeout.unchk_short", int'(err_short), 0);
        chk("timeout.unchk_long", int'(err_long), 0);
        chk("timeout.mark_cnt", int'(mark_cnt), marks_sent);
        repeat (3) applyStimulus(20, 1'b0, 1'b0);
        chk("timeout.relock", int'(lock), 1);

        phase = "event";
        for (int i = 0; i < 7; i++) usTick(1'b0);
        evtPulse(1'b0);
        chk("evtA.vld", int'(evt_vld), 1);
        chk("evtA.us", int'(evt_us), 7);
        chk("evtA.mark", int'(evt_mark), marks_sent);
        chk("evtA.ovr", int'(evt_ovr), 0);
        usTick(1'b0);
        usTick(1'b0);
        evtPulse(1'b0);
        chk("evtB.ovr", int'(evt_ovr), 1);
        chk("evtB.us", int'(evt_us), 7);
        chk("evtB.vld", int'(evt_vld), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ack.vld", int'(evt_vld), 0);
        chk("ack.ovr", int'(evt_ovr), 0);
        evtPulse(1'b0);
        evtPulse(1'b0);
        chk("evtD.ovr", int'(evt_ovr), 1);
        chk("evtD.us", int'(evt_us), 9);
        usTick(1'b0);
        evtPulse(1'b1);
        chk("evtE.vld", int'(evt_vld), 1);
        chk("evtE.ovr", int'(evt_ovr), 0);
        chk("evtE.us", int'(evt_us), 10);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        phase = "random";
        for (int p = 0; p < 40; p++) begin
            int  n;
            bit  coin;
            n    = $urandom_range(15, 25);
            coin = $urandom_range(0, 1);
            for (int i = 0; i < n - (coin ? 1 : 0); i++) begin
                rstep(1'b1, 1'b0);
                rstep(1'b0, 1'b0);
                if ($urandom_range(0, 2) == 0) rstep(1'b0, 1'b0);
            end
            if (coin) rstep(1'b1, 1'b1);
            else      rstep(1'b0, 1'b1);
            rstep(1'b0, 1'b0);
        end
        ev_lvl = 1'b0;
        idle(5);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        phase = "prereset";
        repeat (5) applyStimulus(20, 1'b0, 1'b0);
        chk("prereset.lock", int'(lock), 1);
        for (int i = 0; i < 5; i++) usTick(1'b0);
        evtPulse(1'b0);
        chk("prereset.evt_vld", int'(evt_vld), 1);
        for (int i = 0; i < 3; i++) usTick(1'b0);

        #2;
        t1us_in = 1'b0; mark_in = 1'b0; evt_in = 1'b0; evt_ack = 1'b0; err_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_rst");
        modelReset();
        marks_sent = 0;
        repeat (2) @(posedge clk20mhz);
        #1;
        rst_n = 1'b1;

        phase = "postreset";
        for (int i = 0; i < 3; i++) usTick(1'b0);
        chk("postreset.us_cnt", int'(us_cnt), 3);
        chk("postreset.lock", int'(lock), 0);
        chk("postreset.mark_cnt", int'(mark_cnt), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("postreset.period", int'(period_us), 3);
        chk("postreset.mark1", int'(mark_cnt), 1);
        chk("postreset.no_err", int'(err_short | err_long), 0);
        repeat (3) applyStimulus(20, 1'b0, 1'b0);
        chk("postreset.relock", int'(lock), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
